// File: rtl/gpr_file_sb.sv
// General-purpose register bank with two writeback ports, same-cycle write-to-read
// bypass and a per-register busy scoreboard for decode-stage hazard detection.
module gpr_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 16,
  parameter bit          ZERO_REG   = 1'b0,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] wa0,
  input  logic [DATA_WIDTH-1:0] wd0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] wa1,
  input  logic [DATA_WIDTH-1:0] wd1,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic [DATA_WIDTH-1:0] data_rs,
  output logic [DATA_WIDTH-1:0] data_rt,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam int unsigned         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_A = NUM_REGS[ADDR_WIDTH:0];

  if (NUM_REGS > (2 ** ADDR_WIDTH)) begin : g_bad_cfg
    $error("gpr_file_sb: NUM_REGS exceeds the address space");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
  } rd_t;

  // An address is usable when it names an implemented, non-hardwired register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NUM_REGS_A) && !(ZERO_REG && (a == '0));
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  logic                  wr0_ok;
  logic                  wr1_ok;
  logic                  iss_ok;
  logic [NUM_REGS-1:0]   wen0_vec;
  logic [NUM_REGS-1:0]   wen1_vec;
  logic [NUM_REGS-1:0]   iss_vec;
  rd_t                   rd_a;
  rd_t                   rd_b;

  // Reset gates every request so nothing in flight during reset reaches state or bypass.
  assign wr0_ok = !rst && we0 && addr_ok(wa0);
  assign wr1_ok = !rst && we1 && addr_ok(wa1);
  assign iss_ok = !rst && issue_en && addr_ok(issue_rd);

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wen0_vec = '0;
    wen1_vec = '0;
    iss_vec  = '0;
    if (wr0_ok) wen0_vec[wa0[IDX_W-1:0]] = 1'b1;
    if (wr1_ok) wen1_vec[wa1[IDX_W-1:0]] = 1'b1;
    if (iss_ok) iss_vec[issue_rd[IDX_W-1:0]] = 1'b1;
  end

  // Load writeback (port 1) takes priority over ALU writeback on a shared address.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (wen1_vec[i]) begin
        regs_d[i] = wd1;
      end else if (wen0_vec[i]) begin
        regs_d[i] = wd0;
      end
    end
  end

  // A fresh issue supersedes a completing writeback to the same register.
  assign busy_d = iss_vec | (busy_q & ~(wen0_vec | wen1_vec));

  // NOTE: this storage is a flop array, not a RAM macro, so it takes the async
  // reset like any other state; unwritten registers must read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // Forwarded reads report not-busy: the value the consumer waits for is on the bus now.
  function automatic rd_t read_port(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] stored_data,
                                    input logic                  stored_busy);
    rd_t r;
    r.data = stored_data;
    r.busy = stored_busy;
    if (rst || !addr_ok(a)) begin
      r.data = '0;
      r.busy = 1'b0;
    end else if (BYPASS && wr1_ok && (wa1 == a)) begin
      r.data = wd1;
      r.busy = 1'b0;
    end else if (BYPASS && wr0_ok && (wa0 == a)) begin
      r.data = wd0;
      r.busy = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    rd_a = read_port(rs, regs_q[rs[IDX_W-1:0]], busy_q[rs[IDX_W-1:0]]);
    rd_b = read_port(rt, regs_q[rt[IDX_W-1:0]], busy_q[rt[IDX_W-1:0]]);
  end

  assign data_rs = rd_a.data;
  assign rs_busy = rd_a.busy;
  assign data_rt = rd_b.data;
  assign rt_busy = rd_b.busy;

endmodule
